// File: rtl/tff_pkg.sv
// Shared types for the toggle flip-flop counter controller:
// FSM state encoding and count-direction constants.
package tff_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/tff_sync_reset.sv
// One-bit T flip-flop with synchronous active-high reset.
// Ports: T (toggle enable), clk, syncReset, Q, notQ.
module tff_sync_reset (
  input  logic clk,
  input  logic syncReset,
  input  logic T,
  output logic Q,
  output logic notQ
);

  always_ff @(posedge clk) begin
    if (syncReset) begin
      Q <= 1'b0;
    end else if (T) begin
      Q <= ~Q;
    end
  end

  assign notQ = ~Q;

endmodule

// File: rtl/tff_counter_ctrl.sv
// Drives the T enables of a WIDTH-bit toggle flip-flop bank so it acts
// as a load/up/down counter with one-shot or wrap modes.
// Ports: clk, syncReset, start, stop, dir, oneShot, limit in;
//        T, Q, busy, done out.
module tff_counter_ctrl
  import tff_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             syncReset,
  input  logic             start,
  input  logic             stop,
  input  logic             dir,
  input  logic             oneShot,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] T,
  output logic [WIDTH-1:0] Q,
  output logic             busy,
  output logic             done
);

  state_t           state_q, state_d;
  logic             dir_q;
  logic             one_q;
  logic [WIDTH-1:0] lim_q;
  logic             done_q, done_d;

  logic [WIDTH-1:0] q_n;
  logic [WIDTH-1:0] start_val;
  logic             at_term;
  logic [WIDTH-1:0] up_t;
  logic [WIDTH-1:0] dn_t;
  logic [WIDTH-1:0] lowm;

  for (genvar g = 0; g < WIDTH; g++) begin : g_bank
    tff_sync_reset u_tff (
      .clk       (clk),
      .syncReset (syncReset),
      .T         (T[g]),
      .Q         (Q[g]),
      .notQ      (q_n[g])
    );
  end

  always_comb begin
    start_val = (dir_q == DIR_UP) ? '0 : lim_q;
    at_term   = (dir_q == DIR_DOWN) ? (Q == '0) : (Q == lim_q);
    lowm      = '0;
    up_t      = '0;
    dn_t      = '0;
    // Bit i toggles when every lower bit is 1 (up) or 0 (down).
    for (int i = 0; i < WIDTH; i++) begin
      lowm    = (WIDTH'(1) << i) - WIDTH'(1);
      up_t[i] = ((Q & lowm) == lowm);
      dn_t[i] = ((q_n & lowm) == lowm);
    end

    T       = '0;
    state_d = state_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) state_d = LOAD;
      end
      LOAD: begin
        T       = Q ^ start_val;
        state_d = RUN;
      end
      RUN: begin
        // stop wins over terminal: freeze Q, no done.
        if (stop) begin
          state_d = IDLE;
        end else if (at_term) begin
          done_d = 1'b1;
          if (one_q) state_d = IDLE;
          else       T       = Q ^ start_val;
        end else begin
          T = (dir_q == DIR_UP) ? up_t : dn_t;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (syncReset) begin
      state_q <= IDLE;
      dir_q   <= 1'b0;
      one_q   <= 1'b0;
      lim_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      if (state_q == IDLE && start) begin
        dir_q <= dir;
        one_q <= oneShot;
        lim_q <= limit;
      end
    end
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;

endmodule

// File: tb/tb_tff_counter_ctrl.sv
// Scoreboard bench for tff_counter_ctrl: directed cycles push expected
// Q/busy/done (and optionally T) after each edge; a monitor checks them.
module tb_tff_counter_ctrl;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         syncReset = 1'b1;
  logic         start = 1'b0;
  logic         stop = 1'b0;
  logic         dir = 1'b0;
  logic         oneShot = 1'b0;
  logic [W-1:0] limit = '0;
  logic [W-1:0] T;
  logic [W-1:0] Q;
  logic         busy;
  logic         done;

  always #5 clk = ~clk;

  tff_counter_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .syncReset (syncReset),
    .start     (start),
    .stop      (stop),
    .dir       (dir),
    .oneShot   (oneShot),
    .limit     (limit),
    .T         (T),
    .Q         (Q),
    .busy      (busy),
    .done      (done)
  );

  typedef struct packed {
    int           id;
    logic [W-1:0] q;
    logic         busy;
    logic         done;
    logic         ct;
    logic [W-1:0] t;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   tag   = 0;

  task automatic cyct(input logic st, input logic sp, input logic rs,
                      input logic [W-1:0] eq, input logic eb,
                      input logic ed, input logic ct,
                      input logic [W-1:0] et);
    exp_t e;
    @(negedge clk);
    start     = st;
    stop      = sp;
    syncReset = rs;
    @(posedge clk);
    e.id   = tag;
    e.q    = eq;
    e.busy = eb;
    e.done = ed;
    e.ct   = ct;
    e.t    = et;
    sb.push_back(e);
    tag++;
  endtask

  task automatic cyc(input logic st, input logic sp, input logic rs,
                     input logic [W-1:0] eq, input logic eb,
                     input logic ed);
    cyct(st, sp, rs, eq, eb, ed, 1'b0, '0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        n_vec++;
        if (Q !== e.q || busy !== e.busy || done !== e.done ||
            (e.ct && T !== e.t)) begin
          n_bad++;
          $display("FAIL vec%0d: got Q=%h busy=%b done=%b T=%b, want Q=%h busy=%b done=%b T=%b%s",
                   e.id, Q, busy, done, T, e.q, e.busy, e.done, e.t,
                   e.ct ? "" : "(unchecked)");
        end
      end
    end
  end

  initial begin : stim
    int guard;

    // reset
    cyct(0, 0, 1, 4'd0, 0, 0, 1, 4'b0000);
    cyct(0, 0, 1, 4'd0, 0, 0, 1, 4'b0000);
    cyct(0, 0, 0, 4'd0, 0, 0, 1, 4'b0000);

    // 1: up, oneShot, limit 5
    dir = 1; oneShot = 1; limit = 4'd5;
    cyc(1, 0, 0, 4'd0, 1, 0);
    cyc(0, 0, 0, 4'd0, 1, 0);
    for (int k = 1; k <= 5; k++) cyc(0, 0, 0, 4'(k), 1, 0);
    cyc(0, 0, 0, 4'd5, 0, 1);
    cyct(0, 0, 0, 4'd5, 0, 0, 1, 4'b0000);
    cyc(0, 0, 0, 4'd5, 0, 0);

    // 2: down, continuous, limit 3, then stop
    dir = 0; oneShot = 0; limit = 4'd3;
    cyc(1, 0, 0, 4'd5, 1, 0);
    cyc(0, 0, 0, 4'd3, 1, 0);
    cyct(0, 0, 0, 4'd2, 1, 0, 1, 4'b0011);
    cyc(0, 0, 0, 4'd1, 1, 0);
    cyct(0, 0, 0, 4'd0, 1, 0, 1, 4'b0011);
    cyc(0, 0, 0, 4'd3, 1, 1);
    cyc(0, 0, 0, 4'd2, 1, 0);
    cyc(0, 0, 0, 4'd1, 1, 0);
    cyc(0, 0, 0, 4'd0, 1, 0);
    cyc(0, 0, 0, 4'd3, 1, 1);
    cyc(0, 0, 0, 4'd2, 1, 0);
    cyc(0, 1, 0, 4'd2, 0, 0);
    cyc(0, 0, 0, 4'd2, 0, 0);

    // 3: up, continuous, limit 15, wraps twice, stop at 6
    dir = 1; oneShot = 0; limit = 4'd15;
    cyc(1, 0, 0, 4'd2, 1, 0);
    cyc(0, 0, 0, 4'd0, 1, 0);
    for (int r = 0; r < 2; r++) begin
      for (int k = 1; k <= 15; k++) begin
        if (k == 3)
          cyct(0, 0, 0, 4'(k), 1, 0, 1, 4'b0111);
        else if (k == 15)
          cyct(0, 0, 0, 4'(k), 1, 0, 1, 4'b1111);
        else
          cyc(0, 0, 0, 4'(k), 1, 0);
      end
      cyc(0, 0, 0, 4'd0, 1, 1);
    end
    for (int k = 1; k <= 6; k++) cyc(0, 0, 0, 4'(k), 1, 0);
    cyc(0, 1, 0, 4'd6, 0, 0);
    cyc(0, 0, 0, 4'd6, 0, 0);

    // 4a: stop in the terminal cycle
    dir = 1; oneShot = 1; limit = 4'd2;
    cyc(1, 0, 0, 4'd6, 1, 0);
    cyc(0, 0, 0, 4'd0, 1, 0);
    cyc(0, 0, 0, 4'd1, 1, 0);
    cyc(0, 0, 0, 4'd2, 1, 0);
    cyc(0, 1, 0, 4'd2, 0, 0);
    cyc(0, 0, 0, 4'd2, 0, 0);
    cyc(0, 0, 0, 4'd2, 0, 0);

    // 4b: start and limit change mid-RUN are ignored
    limit = 4'd4;
    cyc(1, 0, 0, 4'd2, 1, 0);
    cyc(0, 0, 0, 4'd0, 1, 0);
    cyc(0, 0, 0, 4'd1, 1, 0);
    limit = 4'd9;
    cyc(1, 0, 0, 4'd2, 1, 0);
    cyc(0, 0, 0, 4'd3, 1, 0);
    cyc(0, 0, 0, 4'd4, 1, 0);
    cyc(0, 0, 0, 4'd4, 0, 1);
    cyc(0, 0, 0, 4'd4, 0, 0);

    // 5: limit 0, up then down, oneShot
    dir = 1; oneShot = 1; limit = 4'd0;
    cyc(1, 0, 0, 4'd4, 1, 0);
    cyc(0, 0, 0, 4'd0, 1, 0);
    cyc(0, 0, 0, 4'd0, 0, 1);
    cyc(0, 0, 0, 4'd0, 0, 0);
    dir = 0;
    cyc(1, 0, 0, 4'd0, 1, 0);
    cyc(0, 0, 0, 4'd0, 1, 0);
    cyc(0, 0, 0, 4'd0, 0, 1);
    cyc(0, 0, 0, 4'd0, 0, 0);

    // 6: reset mid-RUN at Q=9, then a fresh count
    dir = 1; oneShot = 0; limit = 4'd15;
    cyc(1, 0, 0, 4'd0, 1, 0);
    cyc(0, 0, 0, 4'd0, 1, 0);
    for (int k = 1; k <= 9; k++) cyc(0, 0, 0, 4'(k), 1, 0);
    cyct(0, 0, 1, 4'd0, 0, 0, 1, 4'b0000);
    cyct(0, 0, 1, 4'd0, 0, 0, 1, 4'b0000);
    dir = 1; oneShot = 1; limit = 4'd3;
    cyc(1, 0, 0, 4'd0, 1, 0);
    cyc(0, 0, 0, 4'd0, 1, 0);
    cyc(0, 0, 0, 4'd1, 1, 0);
    cyc(0, 0, 0, 4'd2, 1, 0);
    cyc(0, 0, 0, 4'd3, 1, 0);
    cyc(0, 0, 0, 4'd3, 0, 1);
    cyc(0, 0, 0, 4'd3, 0, 0);

    guard = 0;
    while (sb.size() > 0 && guard < 10) begin
      @(posedge clk);
      guard++;
    end
    @(posedge clk);
    #2;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations pending, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/tff_counter_ctrl.md
# tff_counter_ctrl

Sequencing controller for a bank of toggle flip-flops. It drives the per-bit T enables of WIDTH toggle flip-flops so that the bank behaves as a programmable up/down counter with load, terminal count, one-shot or continuous modes, and a start/stop/done handshake. Every change to the bank state, including the initial load, is made only through the T inputs. It sits between the lab's control inputs (buttons/switches) and the flip-flop datapath.

## Interface
- WIDTH, 4, number of toggle flip-flops in the bank (counter width)

- clk  in  1  rising-edge clock
- syncReset  in  1  synchronous, active-high reset
- start  in  1  request to begin a count; sampled only in IDLE
- stop  in  1  abort request; sampled only in RUN
- dir  in  1  1 = count up (0 → limit), 0 = count down (limit → 0); latched on start
- oneShot  in  1  1 = stop at terminal, 0 = wrap and keep counting; latched on start
- limit  in  WIDTH  terminal/start value; latched on start
- T  out  WIDTH  toggle enables into the bank; combinational from state and Q
- Q  out  WIDTH  bank outputs (counter value)
- busy  out  1  high in LOAD and RUN
- done  out  1  registered one-cycle pulse at terminal count

## Operation
- States: IDLE, LOAD, RUN.
- Reset values (one edge with syncReset = 1):
  - state IDLE
  - Q = 0
  - busy = 0
  - done = 0
  - latched dir/oneShot/limit = 0
- syncReset overrides everything, including mid-RUN.

- IDLE:
  - T = 0, so Q holds.
  - start = 1 latches dir, oneShot and limit, then moves to LOAD.
- LOAD:
  - startVal = 0 if up, latched limit if down.
  - T = Q XOR startVal.
  - Moves to RUN unconditionally.
- RUN, not at terminal:
  - Up: T[0] = 1, T[i] = AND of Q[i-1:0].
  - Down: T[0] = 1, T[i] = AND of ~Q[i-1:0].
- Terminal condition: Q == latched limit (up) or Q == 0 (down).
- RUN, at terminal:
  - oneShot = 1: T = 0, go to IDLE, set done.
  - oneShot = 0: T = Q XOR startVal (wrap), stay in RUN, set done.
- stop in RUN:
  - T = 0 that cycle; Q is frozen at its current value.
  - Go to IDLE; done is not set.
  - stop has priority over the terminal condition.
- Ignored inputs:
  - start outside IDLE.
  - stop outside RUN.
  - Changes to limit, dir or oneShot while busy.
- limit = 0:
  - startVal equals the terminal value, so terminal is true in the first RUN cycle.
  - This holds for both up and down counting.

## Timing
- Edge numbering: start sampled at edge n.
  - Cycle after edge n: LOAD, busy = 1.
  - Edge n+1: Q = startVal, state RUN.
- Counting: Q changes by ±1 per edge from edge n+2 onward.
- Up count, oneShot:
  - Q reaches L at edge n+1+L.
  - Edge n+2+L: state IDLE, done = 1, busy = 0.
  - done clears at edge n+3+L.
- Wrap (continuous mode): Q returns to startVal at the edge following the terminal cycle, and done is high for the cycle after that edge.
- stop latency: busy falls at the first edge after stop is sampled; Q does not change at that edge.
- done is never high for two consecutive cycles, except during a continuous count with limit = 0.

## Structure
- Shared package tff_pkg holds:
  - state encoding constants (IDLE, LOAD, RUN)
  - DIR_UP / DIR_DOWN constants
- Sub-module tff_sync_reset:
  - one-bit T flip-flop with synchronous active-high reset
  - ports T, clk, syncReset, Q, notQ
  - instantiated WIDTH times via generate
- Controller holds:
  - the FSM
  - the latched configuration
  - the combinational T mask
  - the done register

## Test plan
All scenarios use WIDTH = 4.
1. Up, oneShot, limit = 5, start at edge 0 → Q = 0 at edge 1, then 1..5 at edges 2–6, done = 1 only in the cycle after edge 7, busy low from edge 7, Q holds 5 afterwards.
2. Down, continuous, limit = 3 → Q goes 3, 2, 1, 0 at edges 1–4, back to 3 at edge 5 with done pulsing after edge 5, and the pattern repeats with done every 4 cycles.
3. Up, continuous, limit = 15 → wrap 15 → 0 with T = 4'b1111 in the terminal cycle and done once per 16 cycles; stop asserted while Q = 6 → Q stays 6, IDLE, no done.
4. stop and terminal in the same cycle (up, limit = 2, stop high while Q = 2) → IDLE, done stays 0; start pulsed during RUN and limit changed mid-RUN → no effect on the sequence.
5. limit = 0, up, oneShot → Q = 0 at edge 1, done after edge 2, busy low after edge 2.
6. syncReset held 2 cycles mid-RUN (Q = 9) → at the next edge Q = 0, busy = 0, done = 0, T = 0; a subsequent start counts normally.
